ahb_lite_interconnect: RTL

//  Parametrised single-master AHB-Lite decoder + slave-to-master mux for the tile data bus.

---
 rtl/ahb_ic_pkg.sv | 35 +++
 rtl/ahb_ic_watchdog.sv | 30 +++
 rtl/ahb_lite_interconnect.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ahb_ic_pkg.sv
// Shared AHB-Lite encodings, data-phase state type and select-width helper for the
// tile data bus interconnect.
package ahb_ic_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StSlv,
        StErr1,
        StErr2
    } ic_state_e;

    // One extra code beyond the slave indices is reserved for "no slave selected".
    function automatic int unsigned sel_width(input int unsigned num_slaves);
        return $clog2(num_slaves + 1);
    endfunction

    function automatic logic xfer_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_ic_watchdog.sv
// Per-transfer HREADY watchdog: counts stalled data-phase cycles and strobes abort
// on the last allowed wait cycle.
module ahb_ic_watchdog #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic wait_i,
    output logic abort_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] wait_cnt_q;

    assign abort_o = wait_i && (wait_cnt_q == CntLast);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (start_i || abort_o) begin
            wait_cnt_q <= '0;
        end else if (wait_i) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite decoder and response mux with a built-in ERROR default slave,
// an HREADY timeout watchdog and a first-fault error log.
module ahb_lite_interconnect
    import ahb_ic_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF0000}},
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          TIMEOUT_EN     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = 32'hDEADBEEF
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic                             timeout_irq,
    output logic                             err_valid,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    input  logic                             err_clear
);

    localparam int unsigned SelW = sel_width(NUM_SLAVES);
    localparam logic [SelW-1:0] SelNone = SelW'(NUM_SLAVES);

    ic_state_e             state_q;
    logic [SelW-1:0]       sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  timeout_irq_q;
    logic                  err_valid_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    logic [SelW-1:0]       dec_sel;
    logic                  dec_hit;
    logic [DATA_WIDTH-1:0] slv_rdata;
    logic                  slv_ready;
    logic                  slv_resp;
    logic                  addr_active;
    logic                  abort;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] fault_addr;

    // Walk from the top index down so the lowest matching window overrides.
    always_comb begin
        dec_sel = SelNone;
        dec_hit = 1'b0;
        HSEL_S  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((HADDR & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_sel   = SelW'(i);
                dec_hit   = 1'b1;
                HSEL_S    = '0;
                HSEL_S[i] = 1'b1;
            end
        end
    end

    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = HRESP_OKAY;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SelW'(i)) begin
                slv_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                slv_ready = HREADYOUT_S[i];
                slv_resp  = HRESP_S[i];
            end
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        unique case (state_q)
            StIdle: begin
                HREADY = 1'b1;
                HRESP  = HRESP_OKAY;
                HRDATA = '0;
            end
            StSlv: begin
                HREADY = slv_ready;
                HRESP  = slv_resp;
                HRDATA = slv_rdata;
            end
            StErr1: begin
                HREADY = 1'b0;
                HRESP  = HRESP_ERROR;
                HRDATA = DEFAULT_RDATA;
            end
            StErr2: begin
                HREADY = 1'b1;
                HRESP  = HRESP_ERROR;
                HRDATA = DEFAULT_RDATA;
            end
        endcase
    end

    generate
        if (TIMEOUT_EN) begin : g_wdog
            ahb_ic_watchdog #(
                .TimeoutCycles(TIMEOUT_CYCLES)
            ) u_wdog (
                .clk_i  (HCLK),
                .rst_ni (HRESETn),
                .start_i(HREADY),
                .wait_i (state_q == StSlv && !slv_ready),
                .abort_o(abort)
            );
        end else begin : g_no_wdog
            assign abort = 1'b0;
        end
    endgenerate

    // An abort only fires while HREADY is low, so it never coincides with an unmapped accept.
    assign addr_active = HREADY && xfer_active(HTRANS);
    assign fault       = (addr_active && !dec_hit) || abort;
    assign fault_addr  = abort ? addr_q : HADDR;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= StIdle;
            sel_q         <= SelNone;
            addr_q        <= '0;
            timeout_irq_q <= 1'b0;
            err_valid_q   <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            timeout_irq_q <= abort;
            if (HREADY) begin
                addr_q <= HADDR;
                if (addr_active && dec_hit) begin
                    state_q <= StSlv;
                    sel_q   <= dec_sel;
                end else if (addr_active) begin
                    state_q <= StErr1;
                    sel_q   <= SelNone;
                end else begin
                    state_q <= StIdle;
                    sel_q   <= SelNone;
                end
            end else begin
                case (state_q)
                    StErr1: state_q <= StErr2;
                    StSlv: begin
                        if (abort) begin
                            state_q <= StErr1;
                            sel_q   <= SelNone;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
            // A fault in the same cycle as a clear starts a fresh log entry.
            if (fault && (!err_valid_q || err_clear)) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= fault_addr;
            end else if (err_clear) begin
                err_valid_q <= 1'b0;
                err_addr_q  <= '0;
            end
        end
    end

    assign timeout_irq = timeout_irq_q;
    assign err_valid   = err_valid_q;
    assign err_addr    = err_addr_q;

endmodule
